wishbone_line_responder: RTL and testbench
==========================================

// Module: wishbone_line_responder
// PURPOSE
//  Wishbone slave (responder) for line-granular requests from the CPU-side adapter: 12-bit line addr, 128-bit line, 16-bit byte SEL.
//  Serves reads from a one-line holding buffer or the physical-memory (pmem) port.
//  Partial-SEL writes are read-modify-write; the buffer is write-through. Sits between the Wishbone bus and pmem.
// PARAMETERS
//  ADDR_W  12   line address width (byte address = {adr, 4'b0})
//  LINE_W  128  line width in bits; SEL width = LINE_W/8
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       asynchronous, active-high reset
//  wb_cyc       in   1       bus cycle active
//  wb_stb       in   1       request strobe
//  wb_we        in   1       1=write, 0=read
//  wb_adr       in   ADDR_W  line address
//  wb_sel       in   16      byte enables within line
//  wb_dat_m2s   in   LINE_W  write data, bytes already at line offset
//  wb_dat_s2m   out  LINE_W  read data, full line
//  wb_ack       out  1       one-cycle completion pulse
//  wb_stall     out  1       1 = request not accepted this cycle
//  pmem_read    out  1       pmem line read request, held until pmem_resp
//  pmem_write   out  1       pmem line write request, held until pmem_resp
//  pmem_address out  16      line-aligned byte address {adr, 4'b0}
//  pmem_wdata   out  LINE_W  line to write
//  pmem_rdata   in   LINE_W  line read, valid with pmem_resp
//  pmem_resp    in   1       pmem transaction done (single-cycle pulse)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buf_valid=0. Async: pmem_read/pmem_write drop immediately, even mid-transaction.
//  Accept: in IDLE, cyc&stb registers adr/we/sel/dat and leaves IDLE. wb_stall = (state!=IDLE).
//  States: IDLE, FETCH, WRITE, ACK.
//   IDLE : read hit (buf_valid & tag==adr) -> ACK. Read miss -> FETCH.
//          Write sel==FFFF -> WRITE (no fetch). Write 0<sel<FFFF: hit -> WRITE, miss -> FETCH.
//          Write sel==0 -> ACK, no pmem access.
//   FETCH: pmem_read=1; on pmem_resp load buffer (tag=adr, valid=1); -> WRITE if we, else ACK.
//   WRITE: pmem_write=1, pmem_wdata = merge(buf, dat, sel) (full-line write: dat). On pmem_resp buffer <= written line, tag=adr, valid=1 -> ACK.
//   ACK  : wb_ack=1 for exactly one cycle, wb_dat_s2m = buffer line for reads. -> IDLE.
//  Latency (accept edge to ack cycle): read hit 1 cycle; read miss N+1 (N = pmem cycles).
//   Partial-write miss: fetch + write + 1. Full-line or hit write: write + 1.
//  pmem_address/pmem_wdata registered; stable for the whole request. Never read and write together.
//  Merge: byte i = sel[i] ? dat[8i+7:8i] : buf[8i+7:8i].
//  wb_cyc low at any time after accept: the in-flight pmem transaction completes and the buffer updates, but ack is suppressed; -> IDLE.
//  stb in ACK or busy states is ignored (stall=1). No pipelined requests; one outstanding max.
//  pmem_resp outside FETCH/WRITE is ignored. wb_dat_s2m holds its last value outside ACK.
// STRUCTURE
//  lc3b_types additions:
//   - lc3b_line_addr (logic [11:0])
//   - lc3b_byte_sel (logic [15:0])
//   - wb_resp_state_t enum {IDLE, FETCH, WRITE, ACK}
//   - existing lc3b_c_line for line data
//  Sub-module: line_byte_merge (combinational: buf, dat, sel -> merged line), shared with the CPU-side masking logic.
//  Top: FSM, request registers, buffer (valid/tag/data) registers.
// TESTING
//  1. Read miss after reset: adr=12'h010, pmem_resp 3 cycles after pmem_read with rdata=D.
//     -> pmem_address=16'h0100; ack next cycle, wb_dat_s2m=D; stall=1 throughout.
//  2. Repeat read of adr 12'h010. -> no pmem_read; ack 1 cycle after accept, data=D.
//  3. Write adr 12'h010, sel=16'h0030, dat[47:32]=16'hBEEF.
//     -> pmem_write with D bytes 4-5 replaced by BEEF. Ack after resp; re-read returns merged line with no pmem access.
//  4. Partial write miss adr 12'h020, sel=16'h0001. -> FETCH then WRITE, in that order; one ack.
//     Full-line write adr 12'h030, sel=FFFF. -> WRITE only, pmem_wdata=dat.
//  5. wb_cyc dropped during FETCH. -> pmem completes, no ack, next read of that adr hits.
//     Write with sel=0. -> ack in 1 cycle, no pmem activity.
//  6. rst asserted mid-WRITE. -> pmem_write=0 same cycle, no ack, all outputs 0; subsequent read misses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line address, byte select, line data
// and the Wishbone line responder state encoding.
package lc3b_types;

    localparam int LC3B_ADDR_W = 12;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0]   lc3b_line_addr;
    typedef logic [LC3B_LINE_W/8-1:0] lc3b_byte_sel;
    typedef logic [LC3B_LINE_W-1:0]   lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        ACK
    } wb_resp_state_t;

endpackage

// File: rtl/line_byte_merge.sv
// Byte-granular line merge: each byte comes from dat when its sel bit
// is set, otherwise from the base line.
module line_byte_merge #(
    parameter int LINE_W = 128
) (
    input  logic [LINE_W-1:0]   base,
    input  logic [LINE_W-1:0]   dat,
    input  logic [LINE_W/8-1:0] sel,
    output logic [LINE_W-1:0]   merged
);

    always_comb begin
        merged = base;
        for (int i = 0; i < LINE_W/8; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = dat[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wishbone_line_responder.sv
// Wishbone line slave with a one-line write-through holding buffer in
// front of the pmem port; partial writes are read-modify-write.
module wishbone_line_responder
    import lc3b_types::*;
#(
    parameter int ADDR_W = 12,
    parameter int LINE_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_adr,
    input  logic [LINE_W/8-1:0] wb_sel,
    input  logic [LINE_W-1:0]   wb_dat_m2s,
    output logic [LINE_W-1:0]   wb_dat_s2m,
    output logic                wb_ack,
    output logic                wb_stall,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W+3:0]   pmem_address,
    output logic [LINE_W-1:0]   pmem_wdata,
    input  logic [LINE_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    localparam int SEL_W = LINE_W/8;

    wb_resp_state_t state_q, state_d;

    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [SEL_W-1:0]  req_sel;
    logic [LINE_W-1:0] req_dat;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [LINE_W-1:0] buf_data;

    logic aborted_q;
    logic accept;
    logic hit;
    logic sel_full;
    logic sel_none;
    logic abort;

    logic load_wdata;
    logic load_rdat;
    logic rdat_from_pmem;
    logic buf_load;
    logic buf_from_pmem;

    logic [LINE_W-1:0] merge_base;
    logic [LINE_W-1:0] merge_dat;
    logic [SEL_W-1:0]  merge_sel;
    logic [LINE_W-1:0] merged;

    assign accept   = (state_q == IDLE) && wb_cyc && wb_stb;
    assign hit      = buf_valid && (buf_tag == wb_adr);
    assign sel_full = (wb_sel == {SEL_W{1'b1}});
    assign sel_none = (wb_sel == '0);
    assign abort    = aborted_q || !wb_cyc;

    assign wb_stall   = (state_q != IDLE);
    assign wb_ack     = (state_q == ACK) && !abort;
    assign pmem_read  = (state_q == FETCH);
    assign pmem_write = (state_q == WRITE);

    // From IDLE the merge sees the incoming request; after a fetch it
    // merges onto the freshly returned line.
    assign merge_base = (state_q == FETCH) ? pmem_rdata : buf_data;
    assign merge_dat  = (state_q == IDLE) ? wb_dat_m2s : req_dat;
    assign merge_sel  = (state_q == IDLE) ? wb_sel : req_sel;

    line_byte_merge #(
        .LINE_W(LINE_W)
    ) u_merge (
        .base  (merge_base),
        .dat   (merge_dat),
        .sel   (merge_sel),
        .merged(merged)
    );

    always_comb begin
        state_d        = state_q;
        load_wdata     = 1'b0;
        load_rdat      = 1'b0;
        rdat_from_pmem = 1'b0;
        buf_load       = 1'b0;
        buf_from_pmem  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!wb_we) begin
                        if (hit) begin
                            state_d   = ACK;
                            load_rdat = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end else if (sel_none) begin
                        state_d = ACK;
                    end else if (sel_full || hit) begin
                        state_d    = WRITE;
                        load_wdata = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    buf_load      = 1'b1;
                    buf_from_pmem = 1'b1;
                    if (abort) begin
                        state_d = IDLE;
                    end else if (req_we) begin
                        state_d    = WRITE;
                        load_wdata = 1'b1;
                    end else begin
                        state_d        = ACK;
                        load_rdat      = 1'b1;
                        rdat_from_pmem = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    buf_load = 1'b1;
                    state_d  = abort ? IDLE : ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_we       <= 1'b0;
            req_adr      <= '0;
            req_sel      <= '0;
            req_dat      <= '0;
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            buf_data     <= '0;
            aborted_q    <= 1'b0;
            wb_dat_s2m   <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_we       <= wb_we;
                req_adr      <= wb_adr;
                req_sel      <= wb_sel;
                req_dat      <= wb_dat_m2s;
                pmem_address <= {wb_adr, 4'b0000};
            end
            if (load_wdata) begin
                pmem_wdata <= merged;
            end
            if (load_rdat) begin
                wb_dat_s2m <= rdat_from_pmem ? pmem_rdata : buf_data;
            end
            if (buf_load) begin
                buf_valid <= 1'b1;
                buf_tag   <= req_adr;
                buf_data  <= buf_from_pmem ? pmem_rdata : pmem_wdata;
            end
            // A dropped cyc is remembered until the request retires.
            aborted_q <= (state_d != IDLE)
                && (aborted_q || ((state_q != IDLE) && !wb_cyc));
        end
    end

endmodule

// File: tb/tb_wishbone_line_responder.sv
// Scoreboard bench for wishbone_line_responder: directed scenarios plus
// randomized traffic against a line-level reference model.
module tb_wishbone_line_responder;

    localparam int AW = 12;
    localparam int LW = 128;
    localparam int SW = LW/8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_adr = '0;
    logic [SW-1:0] wb_sel = '0;
    logic [LW-1:0] wb_dat_m2s = '0;
    logic [LW-1:0] wb_dat_s2m;
    logic          wb_ack;
    logic          wb_stall;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW+3:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    wishbone_line_responder #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_m2s(wb_dat_m2s),
        .wb_dat_s2m(wb_dat_s2m), .wb_ack(wb_ack), .wb_stall(wb_stall),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        bit          we;
        bit [LW-1:0] dat;
        int          lat;
    } sb_t;
    typedef struct {
        bit          wr;
        bit [15:0]   addr;
        bit [LW-1:0] wdata;
    } op_t;

    sb_t sb_q[$];
    op_t op_q[$];
    bit [LW-1:0] pmem[bit [AW-1:0]];
    bit [LW-1:0] shadow[bit [AW-1:0]];

    bit          m_valid = 0;
    bit [AW-1:0] m_tag = '0;
    bit [LW-1:0] m_line = '0;

    int pmem_lat = 1;
    int accept_cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    function automatic bit [LW-1:0] init_line(bit [AW-1:0] a);
        bit [31:0] x;
        x = 32'(a);
        return {x * 32'h9E3779B1, x ^ 32'h5A5A5A5A,
                x * 32'h85EBCA6B, ~x};
    endfunction

    function automatic bit [LW-1:0] pmem_get(bit [AW-1:0] a);
        return pmem.exists(a) ? pmem[a] : init_line(a);
    endfunction

    function automatic bit [LW-1:0] shadow_get(bit [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_line(a);
    endfunction

    function automatic bit [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what each request must do at line level.
    task automatic predict(bit we, bit [AW-1:0] adr, bit [SW-1:0] sel,
                           bit [LW-1:0] dat, bit push_sb);
        bit hit;
        int nops;
        bit [LW-1:0] base;
        bit [LW-1:0] nl;
        bit [LW-1:0] rd;
        hit = m_valid && (m_tag == adr);
        nops = 0;
        rd = '0;
        if (!we) begin
            if (!hit) begin
                op_q.push_back('{1'b0, {adr, 4'b0}, '0});
                m_line = shadow_get(adr);
                m_valid = 1;
                m_tag = adr;
                nops = 1;
            end
            rd = m_line;
        end else if (sel != '0) begin
            if (sel != '1 && !hit) begin
                op_q.push_back('{1'b0, {adr, 4'b0}, '0});
                nops++;
            end
            base = hit ? m_line : shadow_get(adr);
            nl = base;
            for (int i = 0; i < SW; i++)
                if (sel[i]) nl[8*i +: 8] = dat[8*i +: 8];
            op_q.push_back('{1'b1, {adr, 4'b0}, nl});
            shadow[adr] = nl;
            m_line = nl;
            m_valid = 1;
            m_tag = adr;
            nops++;
        end
        if (push_sb) sb_q.push_back('{we, rd, 1 + nops * pmem_lat});
    endtask

    // pmem responder: checks each transaction, answers after pmem_lat.
    initial begin
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst && (pmem_read || pmem_write)) begin
                op_t got;
                op_t e;
                bit stable;
                bit aborted;
                got = '{pmem_write, pmem_address, pmem_write ? pmem_wdata : '0};
                if (op_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pmem_unexpected: got wr=%0b addr=%h expected none",
                             got.wr, got.addr);
                end else begin
                    e = op_q.pop_front();
                    chk("pmem_kind_addr", {got.wr, got.addr}, {e.wr, e.addr});
                    if (e.wr) chk("pmem_wdata", got.wdata, e.wdata);
                end
                stable = 1;
                aborted = 0;
                for (int k = 1; k < pmem_lat; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    if (pmem_address != got.addr || pmem_write != got.wr
                        || pmem_read == got.wr)
                        stable = 0;
                    if (got.wr && pmem_wdata != got.wdata) stable = 0;
                end
                chk("pmem_stable", stable, 1);
                if (!aborted && !rst) begin
                    if (got.wr) pmem[got.addr[15:4]] = got.wdata;
                    else pmem_rdata = pmem_get(got.addr[15:4]);
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pmem_read && pmem_write) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pmem_rw_both: got read=1 write=1 expected exclusive");
        end
    end

    // Monitor: every ack retires the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_ack) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ack_unexpected: got ack expected none");
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("ack_latency", cyc_cnt - accept_cyc + 1, e.lat);
                    if (!e.we) chk("read_data", wb_dat_s2m, e.dat);
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (wb_stall && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (wb_stall) chk("idle_timeout", wb_stall, 0);
    endtask

    task automatic drive(bit we, bit [AW-1:0] adr, bit [SW-1:0] sel,
                         bit [LW-1:0] dat);
        wb_cyc = 1;
        wb_stb = 1;
        wb_we = we;
        wb_adr = adr;
        wb_sel = sel;
        wb_dat_m2s = dat;
        @(posedge clk);
        #1;
        accept_cyc = cyc_cnt;
        wb_stb = 0;
    endtask

    task automatic req(bit we, bit [AW-1:0] adr, bit [SW-1:0] sel,
                       bit [LW-1:0] dat);
        bit stall_ok;
        bit got_ack;
        wait_idle();
        predict(we, adr, sel, dat, 1);
        drive(we, adr, sel, dat);
        stall_ok = 1;
        got_ack = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (wb_ack) begin
                got_ack = 1;
                break;
            end
            if (!wb_stall) stall_ok = 0;
        end
        if (!got_ack) chk("ack_timeout", got_ack, 1);
        else chk("stall_busy", stall_ok, 1);
        @(posedge clk);
        #1;
        wb_cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [LW-1:0] d;
        bit [SW-1:0] s;
        int t;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {wb_ack, wb_stall, pmem_read, pmem_write,
            pmem_address, wb_dat_s2m, pmem_wdata}, '0);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {wb_ack, wb_stall, pmem_read, pmem_write}, '0);

        pmem_lat = 3;
        req(0, 12'h010, '0, '0);
        req(0, 12'h010, '0, '0);

        pmem_lat = 2;
        d = rand_line();
        d[47:32] = 16'hBEEF;
        req(1, 12'h010, 16'h0030, d);
        req(0, 12'h010, '0, '0);

        req(1, 12'h020, 16'h0001, rand_line());
        req(0, 12'h020, '0, '0);
        req(1, 12'h030, 16'hFFFF, rand_line());
        req(0, 12'h030, '0, '0);

        // cyc dropped while the fetch is in flight
        pmem_lat = 4;
        wait_idle();
        predict(0, 12'h040, '0, '0, 0);
        drive(0, 12'h040, '0, '0);
        @(negedge clk);
        @(negedge clk);
        wb_cyc = 0;
        t = 0;
        while ((wb_stall || op_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort_fetch_done", op_q.size(), 0);
        repeat (3) @(negedge clk);
        req(0, 12'h040, '0, '0);
        req(1, 12'h050, '0, rand_line());

        // reset in the middle of a write
        wait_idle();
        d = rand_line();
        op_q.push_back('{1'b1, {12'h060, 4'b0}, d});
        drive(1, 12'h060, 16'hFFFF, d);
        t = 0;
        while (!pmem_write && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("write_started", pmem_write, 1);
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("rst_mid_write", {wb_ack, wb_stall, pmem_read, pmem_write,
            pmem_address, wb_dat_s2m, pmem_wdata}, '0);
        wb_cyc = 0;
        m_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_op_consumed", op_q.size(), 0);
        pmem_lat = 2;
        req(0, 12'h060, '0, '0);
        req(0, 12'h060, '0, '0);

        for (int n = 0; n < 150; n++) begin
            bit we;
            bit [AW-1:0] a;
            we = $urandom_range(0, 1) == 1;
            a = 12'(12'h100 + $urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = '1;
                default: s = 16'($urandom);
            endcase
            pmem_lat = $urandom_range(1, 4);
            req(we, a, s, rand_line());
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("ops_drained", op_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
